// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports
// and the pending-scoreboard controls. The pipeline is master, the file is slave.
interface reg_file_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0]  rd_addr;
    logic [N_RD*DATA_W-1:0]  rd_data;
    logic [N_RD-1:0]         rd_busy;
    logic                    wr0_en;
    logic [ADDR_W-1:0]       wr0_addr;
    logic [DATA_W-1:0]       wr0_data;
    logic                    wr1_en;
    logic [ADDR_W-1:0]       wr1_addr;
    logic [DATA_W-1:0]       wr1_data;
    logic                    pend_set;
    logic [ADDR_W-1:0]       pend_addr;
    logic                    flush;
    logic [(2**ADDR_W)-1:0]  pend_vec;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               pend_set, pend_addr, flush,
        input  rd_data, rd_busy, pend_vec
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               pend_set, pend_addr, flush,
        output rd_data, rd_busy, pend_vec
    );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised register file with N_RD combinational read ports, two write
// ports (port 0 wins on collision), optional write-to-read bypass and a pending scoreboard.
module reg_file_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int N_RD   = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;
    logic [DEPTH-1:0]  pend_nxt_s;
    logic [DEPTH-1:0]  clr_mask_s;
    logic [DEPTH-1:0]  set_mask_s;
    logic [DEPTH-1:0]  one_s;

    assign one_s = {{(DEPTH-1){1'b0}}, 1'b1};

    // Register storage; port 0 is applied last so it wins an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else begin
            if (bus.wr1_en) begin
                mem_r[bus.wr1_addr] <= bus.wr1_data;
            end
            if (bus.wr0_en) begin
                mem_r[bus.wr0_addr] <= bus.wr0_data;
            end
        end
    end

    // Scoreboard next state: flush dominates, then set beats a port-0 clear
    always_comb begin
        clr_mask_s = '0;
        set_mask_s = '0;
        pend_nxt_s = pend_r;
        if (bus.wr0_en) begin
            clr_mask_s = one_s << bus.wr0_addr;
        end else begin
            clr_mask_s = '0;
        end
        if (bus.pend_set) begin
            set_mask_s = one_s << bus.pend_addr;
        end else begin
            set_mask_s = '0;
        end
        if (bus.flush) begin
            pend_nxt_s = '0;
        end else begin
            pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Pending bits register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign bus.pend_vec = pend_r;

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] val_s;
        logic              busy_s;

        assign ra_s = bus.rd_addr[i*ADDR_W +: ADDR_W];

        // Read mux: reset forces zero, then port 0 bypass, port 1 bypass, storage
        always_comb begin
            val_s  = mem_r[ra_s];
            busy_s = pend_r[ra_s];
            if (!rst_n) begin
                val_s  = '0;
                busy_s = 1'b0;
            end else if (BYPASS && bus.wr0_en && (bus.wr0_addr == ra_s)) begin
                val_s  = bus.wr0_data;
                busy_s = 1'b0;
            end else if (BYPASS && bus.wr1_en && (bus.wr1_addr == ra_s)) begin
                val_s  = bus.wr1_data;
                busy_s = pend_r[ra_s];
            end else begin
                val_s  = mem_r[ra_s];
                busy_s = pend_r[ra_s];
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = val_s;
        assign bus.rd_busy[i]                  = busy_s;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: bypass and non-bypass 8x16 instances plus a
// 16x32 four-port instance, checked against a queue of expected results.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .N_RD(2)) bus_a ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .N_RD(2)) bus_b ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(4), .N_RD(4)) bus_c ();

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));
    reg_file_mp #(.DATA_W(32), .ADDR_W(4), .N_RD(4), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));

    task automatic expect_v(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    // Same stimulus to the bypass and non-bypass instances
    task automatic drv(input logic w0e, input logic [2:0] w0a, input logic [15:0] w0d,
                       input logic w1e, input logic [2:0] w1a, input logic [15:0] w1d,
                       input logic ps, input logic [2:0] pa, input logic fl,
                       input logic [2:0] r0, input logic [2:0] r1);
        bus_a.wr0_en = w0e; bus_a.wr0_addr = w0a; bus_a.wr0_data = w0d;
        bus_a.wr1_en = w1e; bus_a.wr1_addr = w1a; bus_a.wr1_data = w1d;
        bus_a.pend_set = ps; bus_a.pend_addr = pa; bus_a.flush = fl;
        bus_a.rd_addr = {r1, r0};
        bus_b.wr0_en = w0e; bus_b.wr0_addr = w0a; bus_b.wr0_data = w0d;
        bus_b.wr1_en = w1e; bus_b.wr1_addr = w1a; bus_b.wr1_data = w1d;
        bus_b.pend_set = ps; bus_b.pend_addr = pa; bus_b.flush = fl;
        bus_b.rd_addr = {r1, r0};
    endtask

    function automatic logic [15:0] a_rd(input int i);
        return bus_a.rd_data[i*16 +: 16];
    endfunction

    function automatic logic [15:0] b_rd(input int i);
        return bus_b.rd_data[i*16 +: 16];
    endfunction

    initial begin
        logic [3:0]  ca;
        logic [31:0] cv;

        bus_c.wr0_en = 1'b0; bus_c.wr0_addr = 4'd0; bus_c.wr0_data = 32'd0;
        bus_c.wr1_en = 1'b0; bus_c.wr1_addr = 4'd0; bus_c.wr1_data = 32'd0;
        bus_c.pend_set = 1'b0; bus_c.pend_addr = 4'd0; bus_c.flush = 1'b0;
        bus_c.rd_addr = 16'd0;

        // Reset holds outputs at zero even with bypass-matching writes present
        drv(1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 16'h4321, 1'b1, 3'd3, 1'b0, 3'd3, 3'd3);
        #2;
        expect_v("rst_rd0", 64'h0);      check(a_rd(0));
        expect_v("rst_busy", 64'h0);     check(bus_a.rd_busy);
        expect_v("rst_pend", 64'h0);     check(bus_a.pend_vec);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);

        // Bypass vs stored read of R2
        @(negedge clk);
        drv(1'b1, 3'd2, 16'h0007, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        drv(1'b1, 3'd2, 16'h00A0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2);
        #2;
        expect_v("byp_a_same", 64'h00A0); check(a_rd(1));
        expect_v("byp_b_same", 64'h0007); check(b_rd(1));
        @(posedge clk); #1;
        expect_v("byp_b_next", 64'h00A0); check(b_rd(1));

        // Dual write collision on R5
        @(negedge clk);
        drv(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0);
        #2;
        expect_v("coll_a_same", 64'h1111); check(a_rd(0));
        expect_v("coll_b_same", 64'h0000); check(b_rd(0));
        @(negedge clk);
        drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0);
        #2;
        expect_v("coll_a_after", 64'h1111); check(a_rd(0));
        expect_v("coll_b_after", 64'h1111); check(b_rd(0));

        // Scoreboard on R4
        @(negedge clk);
        drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd4, 3'd0);
        #2;
        expect_v("sb_pre_pend", 64'h00);  check(bus_a.pend_vec);
        expect_v("sb_pre_busy", 64'h0);   check(bus_a.rd_busy[0]);
        @(posedge clk); #1;
        expect_v("sb_set_pend", 64'h10);  check(bus_a.pend_vec);
        expect_v("sb_set_busy_a", 64'h1); check(bus_a.rd_busy[0]);
        expect_v("sb_set_busy_b", 64'h1); check(bus_b.rd_busy[0]);
        @(negedge clk);
        drv(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0);
        @(posedge clk); #1;
        expect_v("sb_wr1_pend", 64'h10);  check(bus_a.pend_vec);
        @(negedge clk);
        drv(1'b1, 3'd4, 16'h0044, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0);
        #2;
        expect_v("sb_clr_busy_a", 64'h0);   check(bus_a.rd_busy[0]);
        expect_v("sb_clr_busy_b", 64'h1);   check(bus_b.rd_busy[0]);
        expect_v("sb_clr_rd_a", 64'h0044);  check(a_rd(0));
        @(posedge clk); #1;
        expect_v("sb_clr_pend_a", 64'h00);  check(bus_a.pend_vec);
        expect_v("sb_clr_pend_b", 64'h00);  check(bus_b.pend_vec);

        // Set and port-0 clear on R6 together, then with flush
        @(negedge clk);
        drv(1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0, 3'd6, 3'd0);
        @(posedge clk); #1;
        expect_v("sim_set_wins", 64'h40);   check(bus_a.pend_vec);
        @(negedge clk);
        drv(1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b1, 3'd6, 3'd0);
        @(posedge clk); #1;
        expect_v("sim_flush", 64'h00);      check(bus_a.pend_vec);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        drv(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b0, 3'd3, 3'd0);
        @(negedge clk);
        drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd0);
        #2;
        expect_v("pre_rst_rd", 64'hBEEF);   check(a_rd(0));
        expect_v("pre_rst_pend", 64'h01);   check(bus_a.pend_vec);
        #1;
        rst_n = 1'b0;
        #1;
        expect_v("arst_rd_a", 64'h0);       check(a_rd(0));
        expect_v("arst_rd_b", 64'h0);       check(b_rd(0));
        expect_v("arst_pend", 64'h0);       check(bus_a.pend_vec);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_v("post_rst_rd", 64'h0);     check(b_rd(0));

        // Wide sweep: even registers via port 0, odd via port 1
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cv = 32'(k) * 32'h01010101;
            bus_c.wr0_en = ((k % 2) == 0);
            bus_c.wr1_en = ((k % 2) == 1);
            bus_c.wr0_addr = 4'(k); bus_c.wr0_data = cv;
            bus_c.wr1_addr = 4'(k); bus_c.wr1_data = cv;
        end
        @(negedge clk);
        bus_c.wr0_en = 1'b0;
        bus_c.wr1_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                ca = 4'(j*4 + ((i + j) % 4));
                bus_c.rd_addr[i*4 +: 4] = ca;
            end
            #2;
            for (int i = 0; i < 4; i++) begin
                ca = 4'(j*4 + ((i + j) % 4));
                cv = 32'(ca) * 32'h01010101;
                expect_v($sformatf("sweep_p%0d_r%0d", i, ca), 64'(cv));
                check(64'(bus_c.rd_data[i*32 +: 32]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
